// File: rtl/lhca_uart_tx.sv
// UART 8N1 transmitter for logging the LHCA pattern register.
// One-entry holding buffer in front of the shifter; refused bytes are counted in DROPS.
module lhca_uart_tx #(
    parameter int BAUD_DIV = 104,
    parameter int DROP_W   = 8
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [7:0]        I,
    input  logic              VALID,
    output logic              READY,
    output logic              TX,
    output logic              BUSY,
    output logic [DROP_W-1:0] DROPS
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              full_q, full_d;
    logic              tx_q, tx_d;
    logic [DROP_W-1:0] drops_q, drops_d;

    logic boundary;
    assign boundary = (baud_q == BAUD_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
            drops_q <= drops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        tx_d    = tx_q;
        drops_d = drops_q;

        if (state_q != IDLE)
            baud_d = boundary ? 16'd0 : baud_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (boundary) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (boundary) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (boundary) begin
                    // A waiting byte starts its frame with no idle gap.
                    if (full_q) begin
                        shift_d = hold_q;
                        full_d  = 1'b0;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance uses the registered buffer state, so it never collides with a drain.
        if (VALID && !full_q) begin
            full_d = 1'b1;
            hold_d = I;
        end else if (VALID && full_q && (drops_q != '1)) begin
            drops_d = drops_q + DROP_W'(1);
        end
    end

    assign READY = !full_q;
    assign TX    = tx_q;
    assign BUSY  = (state_q != IDLE);
    assign DROPS = drops_q;

endmodule

// File: tb/tb_lhca_uart_tx.sv
// Bench for lhca_uart_tx: frame table, directed corner sequences and a random run
// against a timeline model of the serial line.
module tb_lhca_uart_tx;

    localparam int B  = 4;
    localparam int DW = 2;
    localparam int FL = 10 * B;

    logic          CLK, RESETN, VALID, READY, TX, BUSY;
    logic [7:0]    I;
    logic [DW-1:0] DROPS;

    lhca_uart_tx #(.BAUD_DIV(B), .DROP_W(DW)) dut (
        .CLK(CLK), .RESETN(RESETN), .I(I), .VALID(VALID),
        .READY(READY), .TX(TX), .BUSY(BUSY), .DROPS(DROPS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_t is the cycle position inside the current frame (-1 = idle line).
    int         m_t;
    logic [9:0] m_frame;
    bit         m_full;
    logic [7:0] m_hold;
    int         m_drops;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_t = -1; m_full = 0; m_hold = '0; m_drops = 0; m_frame = '1;
    endfunction

    function automatic void model_step();
        bit acc, drp;
        if (!RESETN) begin
            model_reset();
            return;
        end
        acc = VALID && !m_full;
        drp = VALID && m_full;
        if ((m_t < 0 && m_full) || (m_t == FL - 1 && m_full)) begin
            m_frame = {1'b1, m_hold, 1'b0};
            m_t     = 0;
            m_full  = 0;
        end else if (m_t == FL - 1) begin
            m_t = -1;
        end else if (m_t >= 0) begin
            m_t++;
        end
        if (acc) begin
            m_full = 1;
            m_hold = I;
        end
        if (drp && m_drops < (1 << DW) - 1) m_drops++;
    endfunction

    function automatic int exp_tx();
        return (m_t < 0) ? 1 : int'(m_frame[m_t / B]);
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("tx",    TX,    exp_tx());
        check("busy",  BUSY,  (m_t >= 0) ? 1 : 0);
        check("ready", READY, m_full ? 0 : 1);
        check("drops", DROPS, m_drops);
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        VALID  = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
    endtask

    task automatic offer(input logic [7:0] b);
        I = b; VALID = 1'b1;
        tick();
        VALID = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame; // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t vecs[4];
    int   busy_cnt;

    initial begin
        vecs[0] = '{data: 8'hA5, exp_frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, exp_frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, exp_frame: 10'b1111111110};
        vecs[3] = '{data: 8'h01, exp_frame: 10'b1000000010};

        I = '0; VALID = 1'b0; RESETN = 1'b0;
        model_reset();
        do_reset();

        // Idle after reset
        for (int c = 0; c < 50; c++) begin
            tick();
            check("idle_tx", TX, 1);
            check("idle_busy", BUSY, 0);
        end

        // Single frames from the table
        for (int v = 0; v < 4; v++) begin
            offer(vecs[v].data);
            check("ready_after_accept", READY, 0);
            check("tx_before_start", TX, 1);
            for (int c = 0; c < FL; c++) begin
                tick();
                check("tbl_tx", TX, int'(vecs[v].exp_frame[c / B]));
                check("tbl_busy", BUSY, 1);
                if (c == 0) check("ready_after_drain", READY, 1);
            end
            tick();
            check("tbl_busy_end", BUSY, 0);
            tick();
        end

        // Back-to-back: 0x01 at k, 0xFF at k+3
        do_reset();
        tick();
        busy_cnt = 0;
        offer(8'h01);
        tick(); if (BUSY) busy_cnt++;
        tick(); if (BUSY) busy_cnt++;
        offer(8'hFF); if (BUSY) busy_cnt++;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (BUSY) busy_cnt++;
        end
        check("b2b_busy_cycles", busy_cnt, 2 * FL);
        check("b2b_drops", DROPS, 0);

        // Three offers, third refused
        do_reset();
        tick();
        offer(8'h11);
        tick();
        offer(8'h22);
        tick();
        I = 8'h33; VALID = 1'b1;
        check("third_ready_low", READY, 0);
        tick();
        VALID = 1'b0;
        check("third_drops", DROPS, 1);
        for (int c = 0; c < 2 * FL + 10; c++) tick();
        check("third_idle", BUSY, 0);

        // Drop counter saturation
        do_reset();
        tick();
        offer(8'h55);
        tick();
        offer(8'h66);
        for (int n = 1; n <= 10; n++) begin
            I = 8'($urandom); VALID = 1'b1;
            tick();
            check("sat_drops", DROPS, (n < 3) ? n : 3);
        end
        VALID = 1'b0;
        for (int c = 0; c < 2 * FL + 10; c++) tick();

        // Asynchronous reset mid-DATA, then a clean frame
        do_reset();
        tick();
        offer(8'hC3);
        for (int c = 0; c < 15; c++) tick();
        check("pre_reset_busy", BUSY, 1);
        #2 RESETN = 1'b0;
        #1;
        model_reset();
        check("async_tx", TX, 1);
        check("async_busy", BUSY, 0);
        check("async_ready", READY, 1);
        tick();
        RESETN = 1'b1;
        tick();
        offer(8'h3C);
        for (int c = 0; c < FL + 5; c++) tick();
        check("post_reset_idle", BUSY, 0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            I     = 8'($urandom);
            VALID = ($urandom_range(0, 19) == 0);
            tick();
        end
        VALID = 1'b0;
        for (int c = 0; c < 2 * FL + 5; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
